// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: default base addresses,
// timer register offsets and CTRL/STATUS bit positions.
package otter_io_pkg;

    localparam logic [31:0] IO_BASE_TIMER = 32'h1100_0100;
    localparam int unsigned IO_WINDOW_LSB = 5;  // 32-byte register windows

    // Timer word offsets (IOBUS_ADDR[4:2])
    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESCALE = 3'd1;
    localparam logic [2:0] TMR_COMPARE  = 3'd2;
    localparam logic [2:0] TMR_COUNT    = 3'd3;
    localparam logic [2:0] TMR_STATUS   = 3'd4;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_MATCH = 0;
    localparam int unsigned STAT_OVF   = 1;

    function automatic logic io_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:IO_WINDOW_LSB] == base[31:IO_WINDOW_LSB];
    endfunction

endpackage

// File: rtl/otter_tick_prescaler.sv
// Divide-by-(div+1) tick generator; held at zero while disabled or when the
// divisor is rewritten.
module otter_tick_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // The tick is decided from the current count, so a clr still lets a
    // pending terminal count fire this cycle.
    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped timer/compare peripheral on the OTTER IOBUS: register file,
// prescaled counter with compare/overflow flags and a level interrupt.
module otter_iobus_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = IO_BASE_TIMER,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           count_q, count_d;
    logic [1:0]            status_q, status_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  intr_q, intr_d;

    logic       hit, we, tick;
    logic [2:0] offset;
    logic       wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic       match_set, ovf_set;

    assign hit         = io_hit(IOBUS_ADDR, BASE_ADDR);
    assign offset      = IOBUS_ADDR[4:2];
    assign we          = IOBUS_WR && hit;
    assign wr_ctrl     = we && (offset == TMR_CTRL);
    assign wr_prescale = we && (offset == TMR_PRESCALE);
    assign wr_compare  = we && (offset == TMR_COMPARE);
    assign wr_count    = we && (offset == TMR_COUNT);
    assign wr_status   = we && (offset == TMR_STATUS);

    otter_tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RST_N(RST_N),
        .en   (ctrl_q[CTRL_EN]),
        .clr  (wr_prescale),
        .div  (prescale_q),
        .tick (tick)
    );

    always_comb begin
        ctrl_d     = wr_ctrl ? IOBUS_OUT[2:0] : ctrl_q;
        prescale_d = wr_prescale ? IOBUS_OUT[PRESCALE_W-1:0] : prescale_q;
        compare_d  = wr_compare ? IOBUS_OUT : compare_q;

        count_d   = count_q;
        match_set = 1'b0;
        ovf_set   = 1'b0;
        // A CPU write to COUNT pre-empts both the increment and the compare.
        if (wr_count) begin
            count_d = IOBUS_OUT;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q[CTRL_RELOAD]) begin
                    count_d = '0;
                end else begin
                    count_d = count_q + 32'd1;
                    ovf_set = (count_q == 32'hFFFF_FFFF);
                end
            end else begin
                count_d = count_q + 32'd1;
                ovf_set = (count_q == 32'hFFFF_FFFF);
            end
        end

        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~IOBUS_OUT[1:0];
        end
        status_d[STAT_MATCH] = status_d[STAT_MATCH] | match_set;
        status_d[STAT_OVF]   = status_d[STAT_OVF] | ovf_set;
    end

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (offset)
                TMR_CTRL:     rdata_d = {29'd0, ctrl_q};
                TMR_PRESCALE: rdata_d = 32'(prescale_q);
                TMR_COMPARE:  rdata_d = compare_q;
                TMR_COUNT:    rdata_d = count_q;
                TMR_STATUS:   rdata_d = {30'd0, status_q};
                default:      rdata_d = '0;
            endcase
        end
        intr_d = ctrl_q[CTRL_IRQ_EN] && status_q[STAT_MATCH];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            count_q    <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            intr_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            intr_q     <= intr_d;
        end
    end

    assign IOBUS_IN = rdata_q;
    assign INTR     = intr_q;

endmodule
